// File: rtl/adc_deser_rx.sv
// Serial ADC receiver: power-up/start sequencing, settle-bit skip, 24-bit MSB-first
// framing and a one-deep output register with sticky overflow.
// Optional macro ADC_RX_DRDY_EN adds adc_drdy_i for DRDY-based frame alignment.
module adc_deser_rx #(
  parameter int PWRUP_CYC = 8000,
  parameter int SKIP_BITS = 1324
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        bit_stb_i,
  input  logic        adc_dout_i,
`ifdef ADC_RX_DRDY_EN
  input  logic        adc_drdy_i,
`endif
  input  logic        clr_ovf_i,
  input  logic        sample_ready_i,
  output logic        adc_pwdn_n_o,
  output logic        adc_start_o,
  output logic [23:0] sample_data_o,
  output logic        sample_valid_o,
  output logic        overflow_o,
  output logic        streaming_o
);

  localparam int MAXC = (PWRUP_CYC > SKIP_BITS) ? PWRUP_CYC : SKIP_BITS;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {S_OFF, S_PWRUP, S_SETTLE, S_STREAM} state_e;

  state_e        state_q;
  logic [CW-1:0] wait_cnt_q;
  logic [4:0]    bit_cnt_q;
  logic [22:0]   shift_q;
  logic          pwdn_n_q, start_q, streaming_q;
  logic [23:0]   data_q;
  logic          valid_q, ovf_q;

  logic [23:0]   frame_d;
  logic          frame_done_d;
  logic          drdy_rise_d;
  logic          drop_d;

`ifdef ADC_RX_DRDY_EN
  logic drdy_prev_q;
`endif

  always_comb begin
    frame_d     = {shift_q, adc_dout_i};
    drdy_rise_d = 1'b0;
`ifdef ADC_RX_DRDY_EN
    drdy_rise_d = bit_stb_i & adc_drdy_i & ~drdy_prev_q;
`endif
    frame_done_d = enable_i && (state_q == S_STREAM) && bit_stb_i &&
                   !drdy_rise_d && (bit_cnt_q == 5'd23);
    drop_d       = frame_done_d && valid_q && !sample_ready_i;
  end

  // Sequencer: outputs are registered alongside the state so they change together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_OFF;
      wait_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      pwdn_n_q    <= 1'b0;
      start_q     <= 1'b0;
      streaming_q <= 1'b0;
`ifdef ADC_RX_DRDY_EN
      drdy_prev_q <= 1'b0;
`endif
    end else if (!enable_i) begin
      state_q     <= S_OFF;
      wait_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      pwdn_n_q    <= 1'b0;
      start_q     <= 1'b0;
      streaming_q <= 1'b0;
`ifdef ADC_RX_DRDY_EN
      drdy_prev_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_OFF: begin
          state_q    <= S_PWRUP;
          pwdn_n_q   <= 1'b1;
          wait_cnt_q <= '0;
        end
        S_PWRUP: begin
          if (wait_cnt_q == CW'(PWRUP_CYC - 1)) begin
            state_q    <= S_SETTLE;
            start_q    <= 1'b1;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        S_SETTLE: begin
          if (bit_stb_i) begin
`ifdef ADC_RX_DRDY_EN
            drdy_prev_q <= adc_drdy_i;
            // First DRDY rise marks the MSB of the first frame.
            if (drdy_rise_d) begin
              state_q     <= S_STREAM;
              streaming_q <= 1'b1;
              shift_q     <= {22'd0, adc_dout_i};
              bit_cnt_q   <= 5'd1;
            end
`else
            if (wait_cnt_q == CW'(SKIP_BITS - 1)) begin
              state_q     <= S_STREAM;
              streaming_q <= 1'b1;
              bit_cnt_q   <= '0;
              wait_cnt_q  <= '0;
            end else begin
              wait_cnt_q <= wait_cnt_q + CW'(1);
            end
`endif
          end
        end
        S_STREAM: begin
          if (bit_stb_i) begin
`ifdef ADC_RX_DRDY_EN
            drdy_prev_q <= adc_drdy_i;
`endif
            if (drdy_rise_d) begin
              shift_q   <= {22'd0, adc_dout_i};
              bit_cnt_q <= 5'd1;
            end else begin
              shift_q   <= frame_d[22:0];
              bit_cnt_q <= (bit_cnt_q == 5'd23) ? 5'd0 : bit_cnt_q + 5'd1;
            end
          end
        end
        default: state_q <= S_OFF;
      endcase
    end
  end

  // One-deep output register; a frame arriving against a stalled word is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (!enable_i) begin
        valid_q <= 1'b0;
      end else if (frame_done_d) begin
        if (!valid_q || sample_ready_i) begin
          data_q  <= frame_d;
          valid_q <= 1'b1;
        end
      end else if (valid_q && sample_ready_i) begin
        valid_q <= 1'b0;
      end
      if (drop_d)         ovf_q <= 1'b1;
      else if (clr_ovf_i) ovf_q <= 1'b0;
    end
  end

  assign adc_pwdn_n_o   = pwdn_n_q;
  assign adc_start_o    = start_q;
  assign streaming_o    = streaming_q;
  assign sample_data_o  = data_q;
  assign sample_valid_o = valid_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_adc_deser_rx.sv
// Bench for adc_deser_rx: timeline-level model checked every cycle plus directed literal checks.
module tb_adc_deser_rx;
  localparam int PWRUP = 16;
  localparam int SKIP  = 9;
  localparam int GAP   = 2;

  logic clk = 0, rst = 1, enable = 0, bit_stb = 0, adc_dout = 0, clr_ovf = 0, sample_ready = 0;
  logic adc_pwdn_n, adc_start, sample_valid, overflow, streaming;
  logic [23:0] sample_data;
`ifdef ADC_RX_DRDY_EN
  logic adc_drdy = 0;
`endif

  adc_deser_rx #(.PWRUP_CYC(PWRUP), .SKIP_BITS(SKIP)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .bit_stb_i(bit_stb), .adc_dout_i(adc_dout),
`ifdef ADC_RX_DRDY_EN
    .adc_drdy_i(adc_drdy),
`endif
    .clr_ovf_i(clr_ovf), .sample_ready_i(sample_ready),
    .adc_pwdn_n_o(adc_pwdn_n), .adc_start_o(adc_start), .sample_data_o(sample_data),
    .sample_valid_o(sample_valid), .overflow_o(overflow), .streaming_o(streaming));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  logic [23:0] got[$];

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: acquisition age since enable, strobe count since START, bit accumulator.
  bit on, m_pwdn, m_start, m_str, m_valid, m_ovf, was_valid, was_start, done;
  int age, nstb;
  bit [23:0] acc, m_data, w;

  always @(posedge clk) begin
    cyc++;
    was_valid = m_valid; was_start = m_start; done = 0;
    if (rst) begin
      on = 0; age = 0; nstb = 0; acc = 0; m_valid = 0; m_data = 0; m_ovf = 0;
      m_start = 0; m_pwdn = 0; m_str = 0;
    end else if (!enable) begin
      on = 0; age = 0; nstb = 0; acc = 0; m_valid = 0; m_start = 0; m_pwdn = 0; m_str = 0;
      if (clr_ovf) m_ovf = 0;
    end else begin
      if (was_start && bit_stb) begin
        nstb++;
        if (nstb > SKIP) begin
          acc = {acc[22:0], adc_dout};
          if ((nstb - SKIP) % 24 == 0) begin done = 1; w = acc; end
        end
      end
      if (!on) begin on = 1; age = 0; end else age++;
      m_pwdn = 1;
      m_start = (age >= PWRUP);
      m_str = m_start && (nstb >= SKIP);
      if (done) begin
        if (!was_valid || sample_ready) begin m_data = w; m_valid = 1; end
        else m_ovf = 1;
      end else if (was_valid && sample_ready) m_valid = 0;
      if (clr_ovf && !(done && was_valid && !sample_ready)) m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    chk("pwdn_n", adc_pwdn_n, m_pwdn);
    chk("start", adc_start, m_start);
    chk("streaming", streaming, m_str);
    chk("valid", sample_valid, m_valid);
    chk("overflow", overflow, m_ovf);
    if (m_valid) chk("data", sample_data, m_data);
    if (sample_valid === 1'b1 && sample_ready === 1'b1) got.push_back(sample_data);
  end

  task automatic send_bits(input logic [23:0] wd, input int n, input bit rdy_last, input bit clr_last);
    for (int i = 23; i >= 24 - n; i--) begin
      repeat (GAP) @(posedge clk);
      #1 adc_dout = wd[i]; bit_stb = 1;
      if (i == 24 - n) begin
        if (rdy_last) sample_ready = 1;
        if (clr_last) clr_ovf = 1;
      end
      @(posedge clk);
      #1 bit_stb = 0; clr_ovf = 0;
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (adc_start !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (adc_start !== 1'b1) chk("start_timeout", adc_start, 1'b1);
  endtask

  initial begin
    int c1, c2, n;
    logic [23:0] exp_words[6];
    exp_words = '{24'hA5C3F0, 24'hA5C3F1, 24'h0F0F0F, 24'hC0FFEE, 24'h000001, 24'h123456};
    c1 = -1; c2 = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pwdn", adc_pwdn_n, 1'b0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_data", sample_data, 24'h0);
    @(posedge clk); #1 rst = 0; enable = 1;

    // Power-up timing: START rises exactly PWRUP clocks after PWDN_N.
    n = 0;
    while (c2 < 0 && n < 200) begin
      @(negedge clk); n++;
      if (c1 < 0 && adc_pwdn_n === 1'b1) c1 = cyc;
      if (c2 < 0 && adc_start === 1'b1) c2 = cyc;
    end
    chk("pwrup_delay", 24'(c2 - c1), 24'(PWRUP));

    // Settle: streaming only after the SKIP-th strobe.
    send_bits(24'h0, SKIP - 1, 0, 0);
    @(negedge clk); chk("settle_not_yet", streaming, 1'b0);
    send_bits(24'h0, 1, 0, 0);
    @(negedge clk); chk("settle_done", streaming, 1'b1);

    // Two back-to-back words with ready high.
    sample_ready = 1;
    send_bits(24'hA5C3F0, 24, 0, 0);
    @(negedge clk); chk("word0_valid", sample_valid, 1'b1); chk("word0", sample_data, 24'hA5C3F0);
    send_bits(24'hA5C3F1, 24, 0, 0);
    @(negedge clk); chk("word1_valid", sample_valid, 1'b1); chk("word1", sample_data, 24'hA5C3F1);

    // Stall over three frames: first word held, overflow after the second.
    @(posedge clk); #1 sample_ready = 0;
    send_bits(24'h0F0F0F, 24, 0, 0);
    @(negedge clk); chk("stall_ovf0", overflow, 1'b0);
    send_bits(24'hF00D01, 24, 0, 0);
    @(negedge clk); chk("stall_ovf1", overflow, 1'b1); chk("stall_hold1", sample_data, 24'h0F0F0F);
    send_bits(24'h5A5A5A, 24, 0, 0);
    @(negedge clk); chk("stall_hold2", sample_data, 24'h0F0F0F);
    @(posedge clk); #1 clr_ovf = 1;
    @(posedge clk); #1 clr_ovf = 0;
    @(negedge clk); chk("clr_ovf", overflow, 1'b0);

    // Handshake coincides with frame completion: new word loads, no overflow.
    send_bits(24'hC0FFEE, 24, 1, 0);
    @(negedge clk); chk("hs_valid", sample_valid, 1'b1); chk("hs_data", sample_data, 24'hC0FFEE);
    chk("hs_ovf", overflow, 1'b0);
    @(posedge clk); #1 sample_ready = 0;

    // clr_ovf coincident with a new drop: set wins.
    send_bits(24'h000001, 24, 0, 0);
    send_bits(24'h000002, 24, 0, 1);
    @(negedge clk); chk("set_wins", overflow, 1'b1); chk("set_hold", sample_data, 24'h000001);
    @(posedge clk); #1 clr_ovf = 1; sample_ready = 1;
    @(posedge clk); #1 clr_ovf = 0; sample_ready = 0;
    @(negedge clk); chk("drain", sample_valid, 1'b0);

    // Enable dropped mid-frame with a held word pending.
    send_bits(24'hABCDEF, 24, 0, 0);
    send_bits(24'h777777, 12, 0, 0);
    #1 enable = 0;
    @(posedge clk); @(negedge clk);
    chk("dis_pwdn", adc_pwdn_n, 1'b0); chk("dis_valid", sample_valid, 1'b0);
    chk("dis_start", adc_start, 1'b0);

    // Re-enable, then reset mid-frame.
    @(posedge clk); #1 enable = 1;
    wait_start();
    send_bits(24'h0, SKIP, 0, 0);
    send_bits(24'h333333, 10, 0, 0);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst2_pwdn", adc_pwdn_n, 1'b0); chk("rst2_str", streaming, 1'b0);
    chk("rst2_data", sample_data, 24'h0); chk("rst2_ovf", overflow, 1'b0);
    @(negedge clk);
    chk("rst2_pwrup", adc_pwdn_n, 1'b1); chk("rst2_nostart", adc_start, 1'b0);

    // Fresh acquisition after reset.
    wait_start();
    send_bits(24'h0, SKIP, 0, 0);
    sample_ready = 1;
    send_bits(24'h123456, 24, 0, 0);
    @(negedge clk); chk("post_rst_word", sample_data, 24'h123456);
    repeat (4) @(posedge clk);

    chk("got_count", 24'(got.size()), 24'd6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk($sformatf("got[%0d]", i), got[i], exp_words[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/adc_deser_rx.md
ADC_DESER_RX -- requirements
Module: adc_deser_rx

Interface
REQ-001 Parameter PWRUP_CYC, default 8000: clk cycles between power-up release and START assertion (80 us at 100 MHz).
REQ-002 Parameter SKIP_BITS, default 1324: bit strobes discarded after START before the first frame MSB (filter settle).
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  level; 1 = run acquisition, 0 = power the ADC down.
REQ-006 bit_stb  in  1  one-clk pulse per ADC SCLK bit, marking the adc_dout sampling point.
REQ-007 adc_dout  in  1  serial ADC data, already LVDS-buffered, MSB first.
REQ-008 clr_ovf  in  1  one-clk pulse clearing the overflow flag.
REQ-009 sample_ready  in  1  downstream accepts sample.
REQ-010 adc_pwdn_n  out  1  active-low ADC power-down.
REQ-011 adc_start  out  1  ADC conversion start level.
REQ-012 sample_data  out  24  assembled sample word.
REQ-013 sample_valid  out  1  sample_data valid.
REQ-014 overflow  out  1  sticky, a word was dropped.
REQ-015 streaming  out  1  FSM in STREAM state.

Function
REQ-016 FSM states OFF, PWRUP, SETTLE, STREAM; encoding free.
REQ-017 OFF: adc_pwdn_n=0, adc_start=0; enable=1 -> PWRUP next cycle.
REQ-018 PWRUP: adc_pwdn_n=1, adc_start=0; after exactly PWRUP_CYC cycles in PWRUP -> SETTLE.
REQ-019 SETTLE: adc_pwdn_n=1, adc_start=1; counts bit_stb pulses; on the SKIP_BITS-th pulse -> STREAM, bit counter zeroed.
REQ-020 STREAM: adc_start=1; each bit_stb shifts adc_dout into shift register LSB; 24th strobe completes a frame, counter wraps to 0.
REQ-021 enable=0 in any state -> OFF next cycle; bit counter, shift register, sample_valid cleared; overflow retained.
REQ-022 Completed frame loads sample_data, sample_valid=1 on the cycle after the 24th strobe (latency 1 clk).
REQ-023 sample_valid holds with stable sample_data until sample_valid&sample_ready; then clears next cycle unless a new frame loads simultaneously.
REQ-024 Frame completes while sample_valid=1 and sample_ready=0: new word dropped, held word kept, overflow=1 next cycle.
REQ-025 Frame completes in same cycle as handshake: new word loads, sample_valid stays 1, no overflow.
REQ-026 clr_ovf and new overflow in same cycle: overflow stays 1 (set wins).
REQ-027 bit_stb in OFF or PWRUP ignored; bit_stb width >1 clk is illegal input.

Reset
REQ-028 rst forces OFF; adc_pwdn_n=0, adc_start=0, sample_data=0, sample_valid=0, overflow=0, streaming=0, all counters 0.
REQ-029 rst mid-frame discards partial bits; acquisition restarts from PWRUP only when enable=1 after rst releases.

Configuration
REQ-030 Macro ADC_RX_DRDY_EN defined: extra input adc_drdy (1 bit, strobe-aligned); in STREAM, rising adc_drdy sampled on bit_stb forces that bit to be MSB (counter=1 after shift), realigning frames; SETTLE exits on first adc_drdy rise instead of SKIP_BITS count.
REQ-031 Macro undefined: no adc_drdy port, framing solely by SKIP_BITS count per REQ-019/020.

Verification
REQ-032 enable=1, PWRUP_CYC=16: adc_start rises exactly 16 clks after adc_pwdn_n rises.
REQ-033 SKIP_BITS=9, serial 24'hA5C3F0 then 24'hA5C3F1, sample_ready=1 -> two words A5C3F0, A5C3F1, valid 1 clk after each 24th strobe.
REQ-034 sample_ready=0 over 3 frames -> sample_data holds first word, overflow=1 after 2nd frame; clr_ovf -> overflow=0.
REQ-035 enable dropped at bit 12 of a frame -> OFF next clk, adc_pwdn_n=0, sample_valid=0, no partial word output.
REQ-036 ADC_RX_DRDY_EN, adc_drdy rise offset by 5 bits from count framing -> words aligned to adc_drdy from next frame.
REQ-037 rst pulsed during STREAM with enable=1 -> all outputs at reset values, PWRUP re-entered cycle after rst release.
